serial_adder_n: RTL and testbench

//   Parametrised multi-cycle adder: computes a + b + cin over WIDTH bits, DIGIT bits per

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/adder_digit.sv | 28 ++
 rtl/serial_adder_n.sv | 135 +++++++++++++
 tb/tb_serial_adder_n.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package serial_adder_pkg;

    // Control FSM encoding
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // Digit counter width: enough bits to count 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_digit.sv
// Combinational DIGIT-bit ripple-carry slice; also exports the carry into its top bit.
module adder_digit #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    // Ripple through the digit; c_msb ends up holding the carry entering bit DIGIT-1
    always_comb begin
        logic carry;
        s     = '0;
        co    = 1'b0;
        c_msb = 1'b0;
        carry = ci;
        for (int i = 0; i < int'(DIGIT); i++) begin
            c_msb = carry;
            s[i]  = x[i] ^ y[i] ^ carry;
            carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/serial_adder_n.sv
// Multi-cycle adder: a + b + cin over WIDTH bits, DIGIT bits per clock through one reused slice.
module serial_adder_n
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned N  = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
    localparam int unsigned CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Reject illegal digit sizes at elaboration
    if (DIGIT == 0 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder_n: DIGIT must divide WIDTH and satisfy 1 <= DIGIT <= WIDTH");
    end

    state_e           state_q;
    state_e           state_d;
    logic             accept_c;
    logic             step_c;
    logic             last_c;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic [CW-1:0]    cnt_q;

    logic [DIGIT-1:0] dig_s;
    logic             dig_co;
    logic             dig_cmsb;
    logic [WIDTH-1:0] sum_nxt_c;

    // The single reused ripple slice works on the low digit of the operand shifters
    adder_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x     (a_q[DIGIT-1:0]),
        .y     (b_q[DIGIT-1:0]),
        .ci    (carry_q),
        .s     (dig_s),
        .co    (dig_co),
        .c_msb (dig_cmsb)
    );

    // New digit enters from the MSB side; the oldest DIGIT bits drop off the bottom
    assign sum_nxt_c = WIDTH'({dig_s, sum_sh_q} >> DIGIT);

    // Next-state and per-cycle control decode
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        step_c   = 1'b0;
        last_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                step_c = 1'b1;
                if (cnt_q == LAST) begin
                    last_c  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand/sum shifters, carry, digit counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            sum_sh_q <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept_c) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= cin;
                cnt_q   <= '0;
                busy    <= 1'b1;
            end
            if (step_c) begin
                a_q      <= a_q >> DIGIT;
                b_q      <= b_q >> DIGIT;
                carry_q  <= dig_co;
                sum_sh_q <= sum_nxt_c;
                cnt_q    <= cnt_q + CW'(1);
            end
            if (last_c) begin
                sum      <= sum_nxt_c;
                cout     <= dig_co;
                overflow <= dig_co ^ dig_cmsb;
                done     <= 1'b1;
                busy     <= 1'b0;
                cnt_q    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed and exhaustive checks of serial_adder_n in four width/digit configurations.
module tb_serial_adder_n;

    logic       clk;
    logic       rst;

    // 8-bit instances share operands, separate starts
    logic       s81, s84;
    logic [7:0] a8, b8;
    logic       cin8;
    logic       busy81, done81, cout81, ovf81;
    logic [7:0] sum81;
    logic       busy84, done84, cout84, ovf84;
    logic [7:0] sum84;

    // 3-bit instances share operands and start
    logic       s3;
    logic [2:0] a3, b3;
    logic       cin3;
    logic       busy31, done31, cout31, ovf31;
    logic [2:0] sum31;
    logic       busy33, done33, cout33, ovf33;
    logic [2:0] sum33;

    int total;
    int bad;

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) u8_1 (
        .clk(clk), .rst(rst), .start(s81), .a(a8), .b(b8), .cin(cin8),
        .busy(busy81), .done(done81), .sum(sum81), .cout(cout81), .overflow(ovf81));

    serial_adder_n #(.WIDTH(8), .DIGIT(4)) u8_4 (
        .clk(clk), .rst(rst), .start(s84), .a(a8), .b(b8), .cin(cin8),
        .busy(busy84), .done(done84), .sum(sum84), .cout(cout84), .overflow(ovf84));

    serial_adder_n #(.WIDTH(3), .DIGIT(1)) u3_1 (
        .clk(clk), .rst(rst), .start(s3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy31), .done(done31), .sum(sum31), .cout(cout31), .overflow(ovf31));

    serial_adder_n #(.WIDTH(3), .DIGIT(3)) u3_3 (
        .clk(clk), .rst(rst), .start(s3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy33), .done(done33), .sum(sum33), .cout(cout33), .overflow(ovf33));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Signed overflow reference for 3-bit two's complement operands
    function automatic logic ovf3_ref(input int x, input int y, input int c);
        int sx;
        int sy;
        int s;
        sx = (x > 3) ? x - 8 : x;
        sy = (y > 3) ? y - 8 : y;
        s  = sx + sy + c;
        return (s > 3) || (s < -4);
    endfunction

    // One addition on both 8-bit instances; operands are scrambled after acceptance
    task automatic run8(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, input logic [7:0] e_sum, input logic e_cout,
                        input logic e_ovf);
        int lat1, lat4, nd1, nd4;
        logic [7:0] r_sum1, r_sum4;
        logic r_c1, r_c4, r_o1, r_o4;
        lat1 = -1; lat4 = -1; nd1 = 0; nd4 = 0;
        r_sum1 = '0; r_sum4 = '0; r_c1 = 1'b0; r_c4 = 1'b0; r_o1 = 1'b0; r_o4 = 1'b0;
        a8 = va; b8 = vb; cin8 = vc;
        s81 = 1'b1; s84 = 1'b1;
        tick();
        s81 = 1'b0; s84 = 1'b0;
        a8 = ~va; b8 = ~vb; cin8 = ~vc;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (done81) begin
                nd1++;
                if (lat1 < 0) begin
                    lat1 = i; r_sum1 = sum81; r_c1 = cout81; r_o1 = ovf81;
                end
            end
            if (done84) begin
                nd4++;
                if (lat4 < 0) begin
                    lat4 = i; r_sum4 = sum84; r_c4 = cout84; r_o4 = ovf84;
                end
            end
        end
        check({tag, " d1 latency"}, 32'(lat1), 32'd8);
        check({tag, " d1 sum"}, 32'(r_sum1), 32'(e_sum));
        check({tag, " d1 cout"}, 32'(r_c1), 32'(e_cout));
        check({tag, " d1 ovf"}, 32'(r_o1), 32'(e_ovf));
        check({tag, " d1 done pulses"}, 32'(nd1), 32'd1);
        check({tag, " d4 latency"}, 32'(lat4), 32'd2);
        check({tag, " d4 sum"}, 32'(r_sum4), 32'(e_sum));
        check({tag, " d4 cout"}, 32'(r_c4), 32'(e_cout));
        check({tag, " d4 ovf"}, 32'(r_o4), 32'(e_ovf));
        check({tag, " d4 done pulses"}, 32'(nd4), 32'd1);
    endtask

    initial begin
        int lat;
        int nd31, nd33;
        logic seen31, seen33;
        logic [3:0] r31, r33;
        logic o31, o33;

        total = 0; bad = 0;
        rst = 1'b1;
        s81 = 1'b0; s84 = 1'b0; s3 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0;
        a3 = '0; b3 = '0; cin3 = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst busy", 32'({busy81, busy84, busy31, busy33}), 32'd0);
        check("rst done", 32'({done81, done84, done31, done33}), 32'd0);
        check("rst sum8", 32'({sum81, sum84}), 32'd0);
        check("rst sum3", 32'({sum31, sum33}), 32'd0);
        check("rst cout", 32'({cout81, cout84, cout31, cout33}), 32'd0);
        check("rst ovf", 32'({ovf81, ovf84, ovf31, ovf33}), 32'd0);

        // Directed 8-bit vectors
        run8("ff+01",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run8("7f+01",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run8("3c+5a+1", 8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0, 1'b1);
        run8("80+80",   8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run8("00+00+1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        run8("a5+5a+1", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);

        // Handshake: start held high, new pair while busy is ignored, next accepted in done cycle
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        s81 = 1'b1;
        tick();
        a8 = 8'h40; b8 = 8'h40; cin8 = 1'b1;
        check("hs busy after accept", 32'(busy81), 32'd1);
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (done81) begin
                lat = i;
                break;
            end
        end
        check("hs first latency", 32'(lat), 32'd8);
        check("hs first sum", 32'(sum81), 32'h46);
        check("hs first flags", 32'({cout81, ovf81}), 32'd0);
        check("hs busy in done cycle", 32'(busy81), 32'd0);
        a8 = 8'h70; b8 = 8'h20; cin8 = 1'b0;
        tick();
        check("hs busy after reaccept", 32'(busy81), 32'd1);
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (done81) begin
                lat = i;
                s81 = 1'b0;
                break;
            end
        end
        s81 = 1'b0;
        check("hs second latency", 32'(lat), 32'd8);
        check("hs second sum", 32'(sum81), 32'h90);
        check("hs second cout", 32'(cout81), 32'd0);
        check("hs second ovf", 32'(ovf81), 32'd1);
        tick();

        // Reset in the middle of an addition
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
        s81 = 1'b1;
        tick();
        s81 = 1'b0;
        tick();
        tick();
        tick();
        check("mid busy before rst", 32'(busy81), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst busy", 32'(busy81), 32'd0);
        check("mid rst done", 32'(done81), 32'd0);
        check("mid rst sum", 32'(sum81), 32'd0);
        check("mid rst cout", 32'(cout81), 32'd0);
        check("mid rst ovf", 32'(ovf81), 32'd0);
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done81) lat++;
        end
        check("mid rst no done", 32'(lat), 32'd0);

        // Exhaustive 3-bit sweep on both digit sizes
        nd31 = 0; nd33 = 0;
        for (int va = 0; va < 8; va++) begin
            for (int vb = 0; vb < 8; vb++) begin
                for (int vc = 0; vc < 2; vc++) begin
                    a3 = 3'(va); b3 = 3'(vb); cin3 = 1'(vc);
                    s3 = 1'b1;
                    tick();
                    s3 = 1'b0;
                    seen31 = 1'b0; seen33 = 1'b0;
                    r31 = '0; r33 = '0; o31 = 1'b0; o33 = 1'b0;
                    for (int i = 1; i <= 6; i++) begin
                        tick();
                        if (done31) begin
                            nd31++; seen31 = 1'b1; r31 = {cout31, sum31}; o31 = ovf31;
                        end
                        if (done33) begin
                            nd33++; seen33 = 1'b1; r33 = {cout33, sum33}; o33 = ovf33;
                        end
                        if (seen31 && seen33) break;
                    end
                    check($sformatf("x3 d1 %0d+%0d+%0d", va, vb, vc), 32'(r31), 32'(va + vb + vc));
                    check($sformatf("x3 d1 ovf %0d+%0d+%0d", va, vb, vc), 32'(o31),
                          32'(ovf3_ref(va, vb, vc)));
                    check($sformatf("x3 d3 %0d+%0d+%0d", va, vb, vc), 32'(r33), 32'(va + vb + vc));
                    check($sformatf("x3 d3 ovf %0d+%0d+%0d", va, vb, vc), 32'(o33),
                          32'(ovf3_ref(va, vb, vc)));
                end
            end
        end
        check("x3 d1 done count", 32'(nd31), 32'd128);
        check("x3 d3 done count", 32'(nd33), 32'd128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
